qeciphy_rx_linkctrl: RTL and testbench
======================================

QECIPHY_RX_LINKCTRL -- requirements
Module: qeciphy_rx_linkctrl

Interface
REQ-001 Parameter RST_HOLD, default 16: cycles o_align_rst_n is held low on each (re)start.
REQ-002 Parameter STEP_TIMEOUT, default 65535: cycles allowed in each bring-up state before retrain.
REQ-003 Parameter ERR_WINDOW, default 4096; ERR_THRESHOLD, default 8: error events per window that force retrain.
REQ-004 rx_clk  in  1  sole clock; all logic SHALL be on rx_clk, one clock domain.
REQ-005 rx_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_align_done / i_align_fail  in  1 each  byte-aligner status.
REQ-007 i_rx_rdy / i_remote_rx_rdy  in  1 each  local / remote channel-decoder ready.
REQ-008 i_fap_missing / i_crc_mismatch  in  1 each  single-cycle error pulses.
REQ-009 i_retrain_req  in  1  software retrain request, level-sampled.
REQ-010 o_align_rst_n  out  1  active-low reset to byte aligner and decoder.
REQ-011 o_link_up  out  1  link usable; o_state  out  3  current FSM state encoding.
REQ-012 o_retrain_cnt  out  8  saturating retrain count; o_fap_cnt, o_crc_cnt  out  16 each; i_stats_clr  in  1.

Function
REQ-013 FSM states SHALL be RESET, ALIGN, WAIT_LOCAL, WAIT_REMOTE, LINK_UP, RETRAIN, encoded 0..5.
REQ-014 RESET: o_align_rst_n=0 for RST_HOLD cycles, then ALIGN.
REQ-015 ALIGN: i_align_done -> WAIT_LOCAL; i_align_fail or step timer = STEP_TIMEOUT -> RETRAIN.
REQ-016 WAIT_LOCAL: i_rx_rdy -> WAIT_REMOTE; timeout -> RETRAIN.
REQ-017 WAIT_REMOTE: i_remote_rx_rdy -> LINK_UP; timeout -> RETRAIN.
REQ-018 Step timer SHALL clear on every state entry; outside RESET o_align_rst_n=1.
REQ-019 Priority per cycle: i_align_fail > success condition > timeout.
REQ-020 LINK_UP: o_link_up=1 (registered, asserted first cycle in LINK_UP); drops of i_align_done, i_rx_rdy or i_remote_rx_rdy -> RETRAIN.
REQ-021 Error event = i_fap_missing | i_crc_mismatch (one event max per cycle).
REQ-022 Window timer runs only in LINK_UP, 0..ERR_WINDOW-1 then wraps; at wrap count reloads to current-cycle event (0 or 1).
REQ-023 Count+event >= ERR_THRESHOLD SHALL cause RETRAIN next cycle; window state clears on LINK_UP exit.
REQ-024 i_retrain_req in any state except RESET/RETRAIN -> RETRAIN; overrides all other transitions.
REQ-025 RETRAIN: one cycle, o_retrain_cnt +1 saturating at 255, then RESET.
REQ-026 o_link_up SHALL fall in the same cycle the FSM leaves LINK_UP.

Reset
REQ-027 rx_rst_n low: state RESET, hold counter 0, o_align_rst_n=0, o_link_up=0, o_state=0, all counters 0.
REQ-028 Reset mid-operation SHALL abort any state immediately; o_retrain_cnt SHALL NOT increment for it.

Configuration
REQ-029 Macro QECIPHY_RX_ERR_STATS_EN defined: o_fap_cnt / o_crc_cnt count respective pulses in any state, saturate at 65535.
REQ-030 i_stats_clr zeroes both; clear with coincident pulse yields 1.
REQ-031 Macro undefined: o_fap_cnt and o_crc_cnt tied to 0, no counter flops; FSM behaviour unchanged.

Structure
REQ-032 qeciphy_pkg SHALL hold the FSM state enum type and the state encoding constants.
REQ-033 Window logic SHALL be sub-module qeciphy_rx_errwindow (inputs enable, event; output trip).

Verification
REQ-034 Clean bring-up: done@30, rx_rdy@40, remote@50 -> LINK_UP, o_link_up=1, o_retrain_cnt=0.
REQ-035 STEP_TIMEOUT=100, no done -> RETRAIN at ALIGN cycle 100, o_retrain_cnt=1, o_align_rst_n low 16 cycles.
REQ-036 In LINK_UP, 8 crc pulses in 4096 cycles -> RETRAIN; 7 pulses then wrap then 1 -> stays LINK_UP.
REQ-037 i_align_done and i_align_fail same cycle in ALIGN -> RETRAIN.
REQ-038 Stats enabled: 65540 fap pulses -> o_fap_cnt=65535; clear with coincident pulse -> 1.
REQ-039 256 retrains -> o_retrain_cnt=255; rx_rst_n low mid-WAIT_REMOTE -> all outputs at reset values.

Source files
------------

// File: rtl/qeciphy_pkg.sv
// -----------------------------------------------------------------------------
// qeciphy_pkg
// Shared types and constants for the QECIPHY receive link controller:
//   - rx_state_e : link-controller FSM states with their fixed encoding
//   - saturation limits for the retrain and error statistics counters
//   - small saturating-increment helpers
// -----------------------------------------------------------------------------
package qeciphy_pkg;

    localparam int STATE_W = 3;

    // Encoding is visible on o_state, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_RESET       = 3'd0,
        ST_ALIGN       = 3'd1,
        ST_WAIT_LOCAL  = 3'd2,
        ST_WAIT_REMOTE = 3'd3,
        ST_LINK_UP     = 3'd4,
        ST_RETRAIN     = 3'd5
    } rx_state_e;

    localparam logic [7:0]  RETRAIN_CNT_MAX = 8'hFF;
    localparam logic [15:0] STAT_CNT_MAX    = 16'hFFFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == RETRAIN_CNT_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == STAT_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/qeciphy_rx_errwindow.sv
// -----------------------------------------------------------------------------
// qeciphy_rx_errwindow
// Counts link error events in fixed windows of ERR_WINDOW cycles and trips when
// a window accumulates ERR_THRESHOLD events.
//   rx_clk, rx_rst_n : clock, async active-low reset
//   i_enable         : window runs only while high; low clears timer and count
//   i_event          : one error event this cycle
//   o_trip           : combinational, high in the cycle the threshold is reached
// Window k covers enabled cycles k*ERR_WINDOW .. (k+1)*ERR_WINDOW-1. The cycle
// where the timer reads 0 starts a new window, so the stale count is ignored
// there and the count restarts from that cycle's event.
// -----------------------------------------------------------------------------
module qeciphy_rx_errwindow
    import qeciphy_pkg::*;
#(
    parameter int ERR_WINDOW    = 4096,
    parameter int ERR_THRESHOLD = 8
) (
    input  logic rx_clk,
    input  logic rx_rst_n,
    input  logic i_enable,
    input  logic i_event,
    output logic o_trip
);

    localparam int TW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int CW = $clog2(ERR_THRESHOLD + 1);
    localparam logic [TW-1:0] T_LAST = TW'(ERR_WINDOW - 1);
    localparam logic [CW:0]   THR    = (CW + 1)'(ERR_THRESHOLD);

    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_count;
    logic          w_start;
    logic [CW:0]   w_sum;

    always_comb begin
        w_start = (r_timer == '0);
        w_sum   = (w_start ? '0 : {1'b0, r_count}) + (CW + 1)'(i_event);
        o_trip  = i_enable && (w_sum >= THR);
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_timer <= '0;
            r_count <= '0;
        end else if (!i_enable) begin
            r_timer <= '0;
            r_count <= '0;
        end else begin
            r_timer <= (r_timer == T_LAST) ? '0 : r_timer + TW'(1);
            // Count never needs to exceed the threshold: a trip ends LINK_UP.
            r_count <= (w_sum >= THR) ? THR[CW-1:0] : w_sum[CW-1:0];
        end
    end

endmodule

// File: rtl/qeciphy_rx_linkctrl.sv
// -----------------------------------------------------------------------------
// qeciphy_rx_linkctrl
// Receive-side link bring-up and supervision FSM:
//   RESET -> ALIGN -> WAIT_LOCAL -> WAIT_REMOTE -> LINK_UP, with RETRAIN on
//   failure, step timeout, link drop, error-window trip or software request.
// Ports:
//   rx_clk, rx_rst_n              : clock, async active-low reset
//   i_align_done, i_align_fail    : byte-aligner status
//   i_rx_rdy, i_remote_rx_rdy     : local / remote decoder ready
//   i_fap_missing, i_crc_mismatch : single-cycle error pulses
//   i_retrain_req                 : software retrain request (level)
//   i_stats_clr                   : clear error statistics
//   o_align_rst_n                 : active-low reset to aligner/decoder
//   o_link_up                     : link usable
//   o_state                       : FSM state encoding
//   o_retrain_cnt                 : saturating retrain count
//   o_fap_cnt, o_crc_cnt          : saturating error statistics
// Build option: QECIPHY_RX_ERR_STATS_EN enables o_fap_cnt / o_crc_cnt;
// without it both are tied to zero.
// i_align_fail is honoured in every bring-up state (ALIGN, WAIT_LOCAL,
// WAIT_REMOTE) and always wins over success and timeout.
// -----------------------------------------------------------------------------
module qeciphy_rx_linkctrl
    import qeciphy_pkg::*;
#(
    parameter int RST_HOLD      = 16,
    parameter int STEP_TIMEOUT  = 65535,
    parameter int ERR_WINDOW    = 4096,
    parameter int ERR_THRESHOLD = 8
) (
    input  logic        rx_clk,
    input  logic        rx_rst_n,
    input  logic        i_align_done,
    input  logic        i_align_fail,
    input  logic        i_rx_rdy,
    input  logic        i_remote_rx_rdy,
    input  logic        i_fap_missing,
    input  logic        i_crc_mismatch,
    input  logic        i_retrain_req,
    input  logic        i_stats_clr,
    output logic        o_align_rst_n,
    output logic        o_link_up,
    output logic [2:0]  o_state,
    output logic [7:0]  o_retrain_cnt,
    output logic [15:0] o_fap_cnt,
    output logic [15:0] o_crc_cnt
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int STEP_W = (STEP_TIMEOUT > 0) ? $clog2(STEP_TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TIMEOUT);

    rx_state_e         r_state, w_next;
    logic [HOLD_W-1:0] r_hold;
    logic [STEP_W-1:0] r_step;
    logic              r_link_up;
    logic              r_align_rst_n;
    logic [7:0]        r_retrain_cnt;

    logic w_bringup;
    logic w_timeout;
    logic w_trip;
    logic w_err_event;
    logic w_in_link;

    assign w_err_event = i_fap_missing | i_crc_mismatch;
    assign w_in_link   = (r_state == ST_LINK_UP);

    qeciphy_rx_errwindow #(
        .ERR_WINDOW   (ERR_WINDOW),
        .ERR_THRESHOLD(ERR_THRESHOLD)
    ) u_errwindow (
        .rx_clk  (rx_clk),
        .rx_rst_n(rx_rst_n),
        .i_enable(w_in_link),
        .i_event (w_err_event),
        .o_trip  (w_trip)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) r_state <= ST_RESET;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_bringup = 1'b0;
        w_timeout = (r_step == STEP_LAST);
        case (r_state)
            ST_RESET: begin
                if (r_hold == HOLD_LAST) w_next = ST_ALIGN;
            end
            ST_ALIGN: begin
                w_bringup = 1'b1;
                if (i_align_fail)      w_next = ST_RETRAIN;
                else if (i_align_done) w_next = ST_WAIT_LOCAL;
                else if (w_timeout)    w_next = ST_RETRAIN;
            end
            ST_WAIT_LOCAL: begin
                w_bringup = 1'b1;
                if (i_align_fail)   w_next = ST_RETRAIN;
                else if (i_rx_rdy)  w_next = ST_WAIT_REMOTE;
                else if (w_timeout) w_next = ST_RETRAIN;
            end
            ST_WAIT_REMOTE: begin
                w_bringup = 1'b1;
                if (i_align_fail)         w_next = ST_RETRAIN;
                else if (i_remote_rx_rdy) w_next = ST_LINK_UP;
                else if (w_timeout)       w_next = ST_RETRAIN;
            end
            ST_LINK_UP: begin
                if (!(i_align_done && i_rx_rdy && i_remote_rx_rdy) || w_trip)
                    w_next = ST_RETRAIN;
            end
            ST_RETRAIN: w_next = ST_RESET;
            default:    w_next = ST_RESET;
        endcase
        // Software request beats everything once the link is past RESET.
        if (i_retrain_req && (r_state != ST_RESET) && (r_state != ST_RETRAIN))
            w_next = ST_RETRAIN;
    end

    // ------------------------------------------------------- timers / flags
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_hold        <= '0;
            r_step        <= '0;
            r_link_up     <= 1'b0;
            r_align_rst_n <= 1'b0;
            r_retrain_cnt <= '0;
        end else begin
            r_hold <= (r_state == ST_RESET && w_next == ST_RESET) ? r_hold + HOLD_W'(1) : '0;
            // Step timer restarts on every state change.
            r_step <= (w_bringup && w_next == r_state) ? r_step + STEP_W'(1) : '0;
            // Registered against the next state so both flags line up with o_state.
            r_link_up     <= (w_next == ST_LINK_UP);
            r_align_rst_n <= (w_next != ST_RESET);
            if (w_next == ST_RETRAIN && r_state != ST_RETRAIN)
                r_retrain_cnt <= sat_inc8(r_retrain_cnt);
        end
    end

    assign o_state       = r_state;
    assign o_link_up     = r_link_up;
    assign o_align_rst_n = r_align_rst_n;
    assign o_retrain_cnt = r_retrain_cnt;

    // ------------------------------------------------------ error statistics
`ifdef QECIPHY_RX_ERR_STATS_EN
    logic [15:0] r_fap_cnt;
    logic [15:0] r_crc_cnt;

    // Clear wins over counting but keeps a coincident pulse.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_fap_cnt <= '0;
            r_crc_cnt <= '0;
        end else begin
            if (i_stats_clr)        r_fap_cnt <= {15'd0, i_fap_missing};
            else if (i_fap_missing) r_fap_cnt <= sat_inc16(r_fap_cnt);
            if (i_stats_clr)         r_crc_cnt <= {15'd0, i_crc_mismatch};
            else if (i_crc_mismatch) r_crc_cnt <= sat_inc16(r_crc_cnt);
        end
    end

    assign o_fap_cnt = r_fap_cnt;
    assign o_crc_cnt = r_crc_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = i_stats_clr;
    assign o_fap_cnt      = '0;
    assign o_crc_cnt      = '0;
`endif

endmodule

// File: tb/tb_qeciphy_rx_linkctrl.sv
module tb_qeciphy_rx_linkctrl;

    localparam int RST_HOLD      = 16;
    localparam int STEP_TIMEOUT  = 100;
    localparam int ERR_WINDOW    = 4096;
    localparam int ERR_THRESHOLD = 8;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n = 1'b1;
    logic        i_align_done = 0, i_align_fail = 0, i_rx_rdy = 0, i_remote_rx_rdy = 0;
    logic        i_fap_missing = 0, i_crc_mismatch = 0, i_retrain_req = 0, i_stats_clr = 0;
    logic        o_align_rst_n, o_link_up;
    logic [2:0]  o_state;
    logic [7:0]  o_retrain_cnt;
    logic [15:0] o_fap_cnt, o_crc_cnt;

    qeciphy_rx_linkctrl #(
        .RST_HOLD(RST_HOLD), .STEP_TIMEOUT(STEP_TIMEOUT),
        .ERR_WINDOW(ERR_WINDOW), .ERR_THRESHOLD(ERR_THRESHOLD)
    ) dut (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n),
        .i_align_done(i_align_done), .i_align_fail(i_align_fail),
        .i_rx_rdy(i_rx_rdy), .i_remote_rx_rdy(i_remote_rx_rdy),
        .i_fap_missing(i_fap_missing), .i_crc_mismatch(i_crc_mismatch),
        .i_retrain_req(i_retrain_req), .i_stats_clr(i_stats_clr),
        .o_align_rst_n(o_align_rst_n), .o_link_up(o_link_up), .o_state(o_state),
        .o_retrain_cnt(o_retrain_cnt), .o_fap_cnt(o_fap_cnt), .o_crc_cnt(o_crc_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h expected %h", name, n_cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------ reference
    // Link state as a number (0 RESET .. 5 RETRAIN), cycles spent in it, and
    // the error count of the current window, where the window index is simply
    // (cycles in LINK_UP) / ERR_WINDOW.
    int m_st, m_age, m_widx, m_wcnt, m_retr, m_fap, m_crc;

    task automatic model_reset();
        m_st = 0; m_age = 0; m_widx = 0; m_wcnt = 0; m_retr = 0; m_fap = 0; m_crc = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit ok;
        nxt = m_st;
        case (m_st)
            0: if (m_age == RST_HOLD - 1) nxt = 1;
            1, 2, 3: begin
                ok = (m_st == 1) ? i_align_done : (m_st == 2) ? i_rx_rdy : i_remote_rx_rdy;
                if (i_align_fail)               nxt = 5;
                else if (ok)                    nxt = m_st + 1;
                else if (m_age >= STEP_TIMEOUT) nxt = 5;
            end
            4: begin
                if (m_age / ERR_WINDOW != m_widx) begin
                    m_widx = m_age / ERR_WINDOW;
                    m_wcnt = 0;
                end
                m_wcnt += int'(i_fap_missing | i_crc_mismatch);
                if (!(i_align_done && i_rx_rdy && i_remote_rx_rdy) || m_wcnt >= ERR_THRESHOLD)
                    nxt = 5;
            end
            default: nxt = 0;
        endcase
        if (i_retrain_req && m_st >= 1 && m_st <= 4) nxt = 5;
        if (nxt == 5 && m_st != 5 && m_retr < 255) m_retr++;
        if (nxt != m_st) begin
            m_age = 0; m_widx = 0; m_wcnt = 0;
        end else begin
            m_age++;
        end
        m_st = nxt;
`ifdef QECIPHY_RX_ERR_STATS_EN
        m_fap = i_stats_clr ? int'(i_fap_missing) : ((m_fap + int'(i_fap_missing) > 65535) ? 65535 : m_fap + int'(i_fap_missing));
        m_crc = i_stats_clr ? int'(i_crc_mismatch) : ((m_crc + int'(i_crc_mismatch) > 65535) ? 65535 : m_crc + int'(i_crc_mismatch));
`endif
    endtask

    // One clock: model advances on the inputs present at the edge, outputs
    // are compared 1 time unit later.
    task automatic cyc();
        logic [44:0] exp_v;
        @(posedge rx_clk);
        model_step();
        n_cyc++;
        #1;
        exp_v = {3'(m_st), (m_st == 4), (m_st != 0), 8'(m_retr), 16'(m_fap), 16'(m_crc)};
        check("model", {o_state, o_link_up, o_align_rst_n, o_retrain_cnt, o_fap_cnt, o_crc_cnt}, exp_v);
    endtask

    task automatic do_reset();
        rx_rst_n = 1'b0;
        #2;
        check("reset_vals", {o_state, o_link_up, o_align_rst_n, o_retrain_cnt, o_fap_cnt, o_crc_cnt}, 45'd0);
        model_reset();
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
    endtask

    task automatic set_link(input logic done, input logic rdy, input logic rem);
        i_align_done = done; i_rx_rdy = rdy; i_remote_rx_rdy = rem;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (o_state != s && n < budget) begin
            cyc();
            n++;
        end
        check(name, o_state, s);
    endtask

    task automatic bring_up();
        set_link(0, 0, 0);
        i_align_fail = 0; i_retrain_req = 0; i_fap_missing = 0; i_crc_mismatch = 0;
        wait_state(3'd1, 200, "bring_up_align");
        set_link(1, 1, 1);
        wait_state(3'd4, 8, "bring_up_link");
    endtask

    typedef struct {
        logic       done, fail, rdy, rem, req;
        int         ncyc;
        logic [2:0] st;
        logic       lu, arst;
        logic [7:0] retr;
    } vec_t;

    function automatic vec_t mk(input logic done, input logic fail, input logic rdy, input logic rem,
                                input logic req, input int ncyc, input logic [2:0] st,
                                input logic lu, input logic arst, input logic [7:0] retr);
        vec_t v;
        v.done = done; v.fail = fail; v.rdy = rdy; v.rem = rem; v.req = req;
        v.ncyc = ncyc; v.st = st; v.lu = lu; v.arst = arst; v.retr = retr;
        return v;
    endfunction

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17];
        int   exp_fap, exp_crc;

        // Cycle numbers count edges after reset release.
        tbl[0]  = mk(0,0,0,0,0, 16, 3'd1, 0,1, 8'd0); // RESET held 16 cycles
        tbl[1]  = mk(0,0,0,0,0, 13, 3'd1, 0,1, 8'd0); // ALIGN up to cycle 29
        tbl[2]  = mk(1,0,0,0,0, 10, 3'd2, 0,1, 8'd0); // done@30
        tbl[3]  = mk(1,0,1,0,0, 10, 3'd3, 0,1, 8'd0); // rx_rdy@40
        tbl[4]  = mk(1,0,1,1,0,  1, 3'd4, 1,1, 8'd0); // remote@50 -> LINK_UP
        tbl[5]  = mk(1,0,1,1,0, 20, 3'd4, 1,1, 8'd0);
        tbl[6]  = mk(1,0,1,1,1,  1, 3'd5, 0,1, 8'd1); // software retrain
        tbl[7]  = mk(0,0,0,0,0,  1, 3'd0, 0,0, 8'd1);
        tbl[8]  = mk(0,0,0,0,0, 16, 3'd1, 0,1, 8'd1);
        tbl[9]  = mk(0,0,0,0,0,100, 3'd1, 0,1, 8'd1); // ALIGN cycles 0..99
        tbl[10] = mk(0,0,0,0,0,  1, 3'd5, 0,1, 8'd2); // timeout at ALIGN cycle 100
        tbl[11] = mk(0,0,0,0,0,  1, 3'd0, 0,0, 8'd2);
        tbl[12] = mk(0,0,0,0,0, 15, 3'd0, 0,0, 8'd2); // still in 16-cycle hold
        tbl[13] = mk(0,0,0,0,0,  1, 3'd1, 0,1, 8'd2);
        tbl[14] = mk(1,1,0,0,0,  1, 3'd5, 0,1, 8'd3); // done and fail together
        tbl[15] = mk(0,0,0,0,0, 17, 3'd1, 0,1, 8'd3);
        tbl[16] = mk(1,0,0,0,0,  1, 3'd2, 0,1, 8'd3);

        #1;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            set_link(tbl[i].done, tbl[i].rdy, tbl[i].rem);
            i_align_fail  = tbl[i].fail;
            i_retrain_req = tbl[i].req;
            repeat (tbl[i].ncyc) cyc();
            check($sformatf("tbl[%0d]", i), {o_state, o_link_up, o_align_rst_n, o_retrain_cnt},
                  {tbl[i].st, tbl[i].lu, tbl[i].arst, tbl[i].retr});
        end
        i_align_fail = 0; i_retrain_req = 0;

        // Eight crc pulses inside one window trip the link.
        bring_up();
        for (int k = 0; k < 8; k++) begin
            repeat (99) cyc();
            i_crc_mismatch = 1; cyc(); i_crc_mismatch = 0;
            if (k < 7) check("win_below_thr", o_state, 3'd4);
            else       check("win_trip", o_state, 3'd5);
        end

        // Seven pulses, then the window wraps, then one more: link survives.
        bring_up();
        for (int k = 0; k < 7; k++) begin
            repeat (99) cyc();
            i_crc_mismatch = 1; cyc(); i_crc_mismatch = 0;
        end
        repeat (ERR_WINDOW + 50 - 700) cyc();
        i_crc_mismatch = 1; cyc(); i_crc_mismatch = 0;
        repeat (5) cyc();
        check("win_wrap_stay", {o_state, o_link_up}, {3'd4, 1'b1});

        // Retrain counter saturation.
        set_link(0, 0, 0);
        for (int k = 0; k < 260; k++) begin
            wait_state(3'd1, 40, "retr_loop_align");
            i_retrain_req = 1; cyc(); i_retrain_req = 0;
        end
        cyc();
        check("retr_sat", o_retrain_cnt, 8'd255);

        // Asynchronous reset in WAIT_REMOTE.
        wait_state(3'd1, 40, "pre_rst_align");
        set_link(1, 1, 0);
        wait_state(3'd3, 5, "pre_rst_wait_remote");
        do_reset();
        set_link(0, 0, 0);
        repeat (3) cyc();

        // Error statistics: a few pulses, then clear.
        for (int k = 0; k < 5; k++) begin
            i_fap_missing = 1; i_crc_mismatch = (k < 3); cyc();
            i_fap_missing = 0; i_crc_mismatch = 0; cyc();
        end
`ifdef QECIPHY_RX_ERR_STATS_EN
        exp_fap = 5; exp_crc = 3;
`else
        exp_fap = 0; exp_crc = 0;
`endif
        check("stats_count", {o_fap_cnt, o_crc_cnt}, {16'(exp_fap), 16'(exp_crc)});
        i_stats_clr = 1; i_fap_missing = 1; cyc();
        i_stats_clr = 0; i_fap_missing = 0;
`ifdef QECIPHY_RX_ERR_STATS_EN
        exp_fap = 1;
`else
        exp_fap = 0;
`endif
        check("stats_clr_pulse", {o_fap_cnt, o_crc_cnt}, {16'(exp_fap), 16'd0});
`ifdef QECIPHY_RX_ERR_STATS_EN
        i_fap_missing = 1;
        repeat (65540) cyc();
        i_fap_missing = 0;
        check("fap_sat", o_fap_cnt, 16'hFFFF);
        i_stats_clr = 1; i_fap_missing = 1; cyc();
        check("fap_clr_coincident", o_fap_cnt, 16'd1);
        i_fap_missing = 0; cyc();
        i_stats_clr = 0;
        check("fap_clr", o_fap_cnt, 16'd0);
`endif

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            i_align_done    = ($urandom_range(0, 99) < 97);
            i_rx_rdy        = ($urandom_range(0, 99) < 97);
            i_remote_rx_rdy = ($urandom_range(0, 99) < 97);
            i_align_fail    = ($urandom_range(0, 199) == 0);
            i_retrain_req   = ($urandom_range(0, 299) == 0);
            i_fap_missing   = ($urandom_range(0, 49) == 0);
            i_crc_mismatch  = ($urandom_range(0, 49) == 0);
            i_stats_clr     = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
